queue_sync_flagged: RTL

Single-clock FIFO queue, the single-domain successor to the team's dual-clock queue. It generalises depth to any value ≥2 (not only powers of two) and adds a registered fill count, programmable almost-full/almost-empty thresholds, a high-water mark and a synchronous flush. It uses the same REQ/ACK handshake and flag names as the existing queue, so producers and consumers in a single clock domain connect without glue.

---
 rtl/queue_sync_flagged.sv | 119 +++++++++++
 1 files changed

// File: rtl/queue_sync_flagged.sv
// queue_sync_flagged: single-clock first-word-fall-through FIFO for any depth >= 2.
// A registered fill count drives every status flag. Pointers wrap explicitly, so the
// depth does not have to be a power of two. A high-water mark and a synchronous flush
// are also provided. The REQ/ACK port names match the dual-clock queue.
module queue_sync_flagged #(
  parameter int BitWidth         = 32,
  parameter int BufferDepth      = 8,
  parameter int AlmostFullLevel  = BufferDepth - 1,
  parameter int AlmostEmptyLevel = 1,
  localparam int CW              = $clog2(BufferDepth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  output logic                dInREQ,
  input  logic                dInACK,
  input  logic [BitWidth-1:0] dIN,
  output logic                dOutACK,
  input  logic                dOutREQ,
  output logic [BitWidth-1:0] dOUT,
  output logic                BufferFull,
  output logic                BufferEmpty,
  output logic                AlmostFull,
  output logic                AlmostEmpty,
  output logic [CW-1:0]       FillCount,
  output logic [CW-1:0]       HighWater
);

  localparam int PW = (BufferDepth > 1) ? $clog2(BufferDepth) : 1;
  localparam logic [PW-1:0] LastSlot = PW'(BufferDepth - 1);

  // Reject parameter sets that the pointer and flag logic cannot represent.
  generate
    if (BufferDepth < 2) begin : g_bad_depth
      $error("queue_sync_flagged: BufferDepth must be >= 2");
    end
    if (AlmostFullLevel < 1 || AlmostFullLevel > BufferDepth) begin : g_bad_afull
      $error("queue_sync_flagged: AlmostFullLevel must be in 1..BufferDepth");
    end
    if (AlmostEmptyLevel < 0 || AlmostEmptyLevel > BufferDepth - 1) begin : g_bad_aempty
      $error("queue_sync_flagged: AlmostEmptyLevel must be in 0..BufferDepth-1");
    end
  endgenerate

  logic [BitWidth-1:0] mem [BufferDepth];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] hw_q, hw_d;
  logic          wen, ren;

  // Decode the flags and handshakes from the registered count. When the queue is full,
  // wptr == rptr, so only the count can tell full from empty.
  always_comb begin
    BufferFull  = (count_q == CW'(BufferDepth));
    BufferEmpty = (count_q == '0);
    AlmostFull  = (count_q >= CW'(AlmostFullLevel));
    AlmostEmpty = (count_q <= CW'(AlmostEmptyLevel));
    dInREQ      = !BufferFull && !flush && !rst;
    dOutACK     = !BufferEmpty && !flush && !rst;
    wen         = dInREQ && dInACK;
    ren         = dOutACK && dOutREQ;
    dOUT        = dOutACK ? mem[rptr_q] : '0;
    FillCount   = count_q;
    HighWater   = hw_q;
  end

  // Compute the next pointer, count and high-water state. A reset or flush overrides
  // any transfer in the same cycle.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    hw_d    = hw_q;
    if (rst || flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      hw_d    = '0;
    end else begin
      if (wen) begin
        wptr_d = (wptr_q == LastSlot) ? '0 : wptr_q + 1'b1;
      end
      if (ren) begin
        rptr_d = (rptr_q == LastSlot) ? '0 : rptr_q + 1'b1;
      end
      case ({wen, ren})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      hw_d = (count_d > hw_q) ? count_d : hw_q;
    end
  end

  // Register the control state. Reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      hw_q    <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      hw_q    <= hw_d;
    end
  end

  // Write into storage. The contents are never cleared. wen already excludes rst and flush.
  always_ff @(posedge clk) begin
    if (wen) begin
      mem[wptr_q] <= dIN;
    end
  end

endmodule
